seg7_ascii_decoder: RTL and testbench
=====================================

# seg7_ascii_decoder

Reverse path of the ASCII-to-7-segment encoder. The block watches an active-low 7-segment pattern, filters it for stability, and decodes each new stable glyph back to an 8-bit ASCII code. Decoded characters go into a small FIFO that a consumer drains with a valid/ready handshake. It sits beside the display driver in the sv_mips debug path, so the core or a UART bridge can read back what the display is showing.

## Interface
- STABLE_CYCLES, 4: consecutive identical qualified samples needed before a pattern is accepted; legal range 1–255.
- FIFO_DEPTH, 4: output FIFO entries; must be a power of two, 2–16.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; one clock domain only.
- HexSeg  in  7  segment pattern; bit value 0 means the segment is lit.
- SegValid  in  1  qualifies HexSeg for this cycle.
- AsciiCode  out  8  head-of-FIFO character; reset value 8'h00.
- AsciiValid  out  1  FIFO not empty; reset value 0.
- AsciiReady  in  1  consumer accepts the head entry when this and AsciiValid are both high.
- Overflow  out  1  sticky; set when a character is dropped because the FIFO is full; reset value 0.
- ErrCount  out  8  only present with SEG2ASCII_ERRCNT_EN; reset value 0.

## Operation
**Input register and stability counter**
- Registered HexSeg/SegValid feed the counter StabCnt, which is ceil(log2(STABLE_CYCLES+1)) bits wide.
- SegValid=0: StabCnt is cleared. LastPattern is kept.
- Sample differs from the previous sample: StabCnt becomes 1.
- Sample equals the previous sample: StabCnt increments, saturating at STABLE_CYCLES.
- StabCnt reaches STABLE_CYCLES in a given cycle: the pattern is accepted once in that cycle.

**Accepted pattern, repeat suppression**
- 7'h7F (blank): nothing is pushed; LastPattern becomes 7'h7F. Blank acts as a separator.
- Any other pattern equal to LastPattern: nothing is pushed. Sending "AA" requires a stable blank between the two glyphs.
- Otherwise: push decode(pattern) and set LastPattern to the pattern. The reset value of LastPattern is 7'h7F.

**Decode (pattern -> ASCII)**
- Digits win over letters; letters decode as uppercase.
- Digits: 40->'0', 4F->'1', 24->'2', 30->'3', 19->'4', 12->'5', 02->'6', 78->'7', 00->'8', 10->'9'.
- Letters: 08->'A', 03->'B', 46->'C', 21->'D', 06->'E', 0E->'F', 09->'H', 61->'J', 47->'L', 6A->'M', 6B->'N', 0C->'P', 18->'Q', 2F->'R', 07->'T', 41->'U', 63->'V', 55->'W', 11->'Y'.
- Other symbols: 77->'_'.
- Any other pattern decodes to '?' (8'h3F) and counts as an error.

**FIFO**
- Entries are 8 bits wide; read and write pointers are log2(FIFO_DEPTH)+1 bits wide.
- AsciiCode always shows the head entry.
- Push with FIFO full and no pop in the same cycle: the character is dropped, Overflow is set, and LastPattern is still updated.
- Push and pop in the same cycle while full: both succeed.
- Push and pop in the same cycle while empty: the pushed character appears on the next cycle; nothing is popped.
- AsciiReady while AsciiValid=0 has no effect.

**Reset**
- Any assertion, including mid-operation, immediately clears the FIFO, StabCnt, Overflow and ErrCount, and sets LastPattern to 7'h7F.
- A partially filtered pattern is discarded.

## Timing
- Pattern applied with SegValid=1 from cycle 0, FIFO empty: the push occurs at the edge ending cycle STABLE_CYCLES, and AsciiValid=1 during cycle STABLE_CYCLES+1.
- A pop at an edge updates AsciiCode/AsciiValid in the following cycle.
- A glitch shorter than STABLE_CYCLES samples produces no push.
- Overflow and ErrCount update in the same cycle as the push they describe.

## Configuration
- SEG2ASCII_ERRCNT_EN defined: the ErrCount port exists.
  - Increments by 1 for each push of '?' and each dropped character.
  - Saturates at 8'hFF; cleared only by reset.
  - A '?' that is itself dropped increments ErrCount by 1, not 2.
- Not defined: the ErrCount port and its logic are absent. Overflow and '?' decoding are unchanged.

## Test plan
- STABLE_CYCLES=4, AsciiReady=1: HexSeg=7'h08 held 6 cycles -> exactly one pop of 8'h41, with AsciiValid first high in cycle 5.
- HexSeg=7'h40 held, then 7'h7F held 4 cycles, then 7'h40 held -> two pops of 8'h30. Without the blank, only one pop.
- HexSeg alternates 7'h06/7'h12 every 2 cycles for 20 cycles -> no push, AsciiValid stays 0.
- AsciiReady=0; six distinct glyphs 7'h03, 46, 21, 06, 0E, 09, each stable and separated -> FIFO holds 'B','C','D','E'; Overflow=1; ErrCount=2 with the macro. Then AsciiReady=1 -> pops in order 42, 43, 44, 45.
- HexSeg=7'h3F stable -> pop 8'h3F; ErrCount=1 with the macro, port absent without it.
- FIFO holding 3 entries, reset pulsed mid-stream -> AsciiValid=0 and Overflow=0 immediately. After release, HexSeg=7'h08 stable -> 8'h41 accepted with no repeat suppression.

Source files
------------

// File: rtl/seg7_ascii_decoder_if.sv
// rtl/seg7_ascii_decoder_if.sv - segment input / ASCII output bundle for seg7_ascii_decoder (ErrCount present with SEG2ASCII_ERRCNT_EN)
interface seg7_ascii_decoder_if;
    logic [6:0] HexSeg;
    logic       SegValid;
    logic [7:0] AsciiCode;
    logic       AsciiValid;
    logic       AsciiReady;
    logic       Overflow;
`ifdef SEG2ASCII_ERRCNT_EN
    logic [7:0] ErrCount;

    modport master (
        output HexSeg, SegValid, AsciiReady,
        input  AsciiCode, AsciiValid, Overflow, ErrCount
    );
    modport slave (
        input  HexSeg, SegValid, AsciiReady,
        output AsciiCode, AsciiValid, Overflow, ErrCount
    );
`else
    modport master (
        output HexSeg, SegValid, AsciiReady,
        input  AsciiCode, AsciiValid, Overflow
    );
    modport slave (
        input  HexSeg, SegValid, AsciiReady,
        output AsciiCode, AsciiValid, Overflow
    );
`endif
endinterface

// File: rtl/seg7_ascii_decoder.sv
// rtl/seg7_ascii_decoder.sv - stable 7-segment glyph to ASCII decoder with output FIFO (optional SEG2ASCII_ERRCNT_EN)
module seg7_ascii_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    seg7_ascii_decoder_if.slave  bus
);
    localparam int             CW       = $clog2(STABLE_CYCLES + 1);
    localparam int             AW       = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0]  STAB_MAX = CW'(STABLE_CYCLES);
    localparam logic [6:0]     BLANK    = 7'h7F;
    localparam logic [7:0]     UNKNOWN  = 8'h3F;

    logic [6:0]    seg_q;
    logic          seg_vld_q;
    logic [6:0]    prev_seg;
    logic [CW-1:0] stab_cnt;
    logic [CW-1:0] stab_nxt;
    logic          accept;
    logic [6:0]    last_pattern;
    logic [7:0]    dec;
    logic          push;
    logic          pop;
    logic          push_ok;
    logic          full;
    logic          empty;
    logic          ovf_q;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    // Digits are listed first so they take precedence over any letter sharing a glyph
    function automatic logic [7:0] decode(input logic [6:0] p);
        logic [7:0] d;
        case (p)
            7'h40: d = "0";
            7'h4F: d = "1";
            7'h24: d = "2";
            7'h30: d = "3";
            7'h19: d = "4";
            7'h12: d = "5";
            7'h02: d = "6";
            7'h78: d = "7";
            7'h00: d = "8";
            7'h10: d = "9";
            7'h08: d = "A";
            7'h03: d = "B";
            7'h46: d = "C";
            7'h21: d = "D";
            7'h06: d = "E";
            7'h0E: d = "F";
            7'h09: d = "H";
            7'h61: d = "J";
            7'h47: d = "L";
            7'h6A: d = "M";
            7'h6B: d = "N";
            7'h0C: d = "P";
            7'h18: d = "Q";
            7'h2F: d = "R";
            7'h07: d = "T";
            7'h41: d = "U";
            7'h63: d = "V";
            7'h55: d = "W";
            7'h11: d = "Y";
            7'h77: d = "_";
            default: d = UNKNOWN;
        endcase
        return d;
    endfunction

    // Stability filter: run length of identical qualified samples, accept once on reaching the threshold
    always_comb begin
        stab_nxt = '0;
        accept   = 1'b0;
        if (seg_vld_q) begin
            if (stab_cnt == '0 || seg_q != prev_seg) begin
                stab_nxt = CW'(1);
            end else if (stab_cnt == STAB_MAX) begin
                stab_nxt = STAB_MAX;
            end else begin
                stab_nxt = stab_cnt + CW'(1);
            end
            accept = (stab_nxt == STAB_MAX) && !(stab_cnt == STAB_MAX && seg_q == prev_seg);
        end
    end

    assign dec     = decode(seg_q);
    assign push    = accept && (seg_q != BLANK) && (seg_q != last_pattern);
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = bus.AsciiReady && !empty;
    assign push_ok = push && (!full || pop);

    // Input register, filter state and repeat-suppression memory
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q        <= BLANK;
            seg_vld_q    <= 1'b0;
            prev_seg     <= BLANK;
            stab_cnt     <= '0;
            last_pattern <= BLANK;
        end else begin
            seg_q     <= bus.HexSeg;
            seg_vld_q <= bus.SegValid;
            prev_seg  <= seg_q;
            stab_cnt  <= stab_nxt;
            // blank resets the memory so the next glyph is always new; dropped glyphs still update it
            if (accept && seg_q != last_pattern) begin
                last_pattern <= seg_q;
            end
        end
    end

    // Output FIFO storage, pointers and sticky overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= dec;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !push_ok) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.AsciiCode  = mem[rd_ptr[AW-1:0]];
    assign bus.AsciiValid = !empty;
    assign bus.Overflow   = ovf_q;

`ifdef SEG2ASCII_ERRCNT_EN
    logic [7:0] err_q;
    logic       err_inc;

    // an unknown glyph that is also dropped is one event, hence the OR
    assign err_inc = push && ((dec == UNKNOWN) || !push_ok);

    // Saturating error counter for unknown glyphs and dropped characters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= '0;
        end else if (err_inc && err_q != 8'hFF) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign bus.ErrCount = err_q;
`endif
endmodule

// File: tb/tb_seg7_ascii_decoder.sv
// tb/tb_seg7_ascii_decoder.sv - scoreboard bench for seg7_ascii_decoder (honours SEG2ASCII_ERRCNT_EN)
module tb_seg7_ascii_decoder;
    localparam int STAB  = 4;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    seg7_ascii_decoder_if bus();

    seg7_ascii_decoder #(.STABLE_CYCLES(STAB), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_pops = 0;

    logic [7:0] tbl [logic [6:0]];
    logic [6:0] pats [$];
    logic [7:0] expq [$];

    // reference model state
    int         run = 0;
    logic [6:0] last_s = 7'h7F;
    logic [6:0] lastpat = 7'h7F;
    int         occ = 0;
    bit         m_ovf = 0;
    int         m_err = 0;
    logic [6:0] d_seg = 7'h7F;
    bit         d_valid = 0;
    bit         m_acc;
    bit         m_pop;
    logic [7:0] m_ch;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_decode(input logic [6:0] p);
        if (tbl.exists(p)) return tbl[p];
        return 8'h3F;
    endfunction

    task automatic build_table();
        logic [6:0] dg [10] = '{7'h40, 7'h4F, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        logic [6:0] lt [19] = '{7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h09, 7'h61, 7'h47, 7'h6A,
                                7'h6B, 7'h0C, 7'h18, 7'h2F, 7'h07, 7'h41, 7'h63, 7'h55, 7'h11};
        string ls = "ABCDEFHJLMNPQRTUVWY";
        for (int i = 0; i < 19; i++) begin
            tbl[lt[i]] = ls[i];
            pats.push_back(lt[i]);
        end
        for (int i = 0; i < 10; i++) begin
            tbl[dg[i]] = 8'h30 + 8'(i);
            pats.push_back(dg[i]);
        end
        tbl[7'h77] = "_";
        pats.push_back(7'h77);
    endtask

    // Model: run length of identical valid samples; a glyph is taken when its run hits STAB exactly
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            run = 0; last_s = 7'h7F; lastpat = 7'h7F; occ = 0;
            m_ovf = 0; m_err = 0; d_seg = 7'h7F; d_valid = 0;
            expq.delete();
        end else begin
            if (!d_valid) run = 0;
            else if (run > 0 && d_seg == last_s) run++;
            else run = 1;
            last_s = d_seg;
            m_acc = d_valid && (run == STAB);
            m_pop = bus.AsciiReady && (occ > 0);
            if (m_acc && d_seg != lastpat) begin
                lastpat = d_seg;
                if (d_seg != 7'h7F) begin
                    m_ch = ref_decode(d_seg);
                    if (occ < DEPTH || m_pop) begin
                        expq.push_back(m_ch);
                        occ++;
                        if (m_ch == 8'h3F && m_err < 255) m_err++;
                    end else begin
                        m_ovf = 1;
                        if (m_err < 255) m_err++;
                    end
                end
            end
            if (m_pop) occ--;
            d_seg = bus.HexSeg;
            d_valid = bus.SegValid;
        end
    end

    // Monitor: compare flags every cycle, pop the scoreboard on each handshake
    always @(negedge clk) begin
        if (!reset) begin
            check("valid", 32'(bus.AsciiValid), 32'(occ > 0));
            check("overflow", 32'(bus.Overflow), 32'(m_ovf));
`ifdef SEG2ASCII_ERRCNT_EN
            check("errcount", 32'(bus.ErrCount), 32'(m_err));
`endif
            if (bus.AsciiValid && bus.AsciiReady) begin
                n_pops++;
                if (expq.size() == 0) begin
                    check("unexpected_pop", 32'(bus.AsciiCode), 32'hFFFF_FFFF);
                end else begin
                    check("code", 32'(bus.AsciiCode), 32'(expq.pop_front()));
                end
            end
        end
    end

    task automatic hold(input logic [6:0] s, input int n, input bit v, input bit rr);
        bus.HexSeg = s;
        bus.SegValid = v;
        repeat (n) begin
            if (rr) bus.AsciiReady = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.HexSeg = 7'h7F;
        bus.SegValid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    int first;
    int p0;
    logic [6:0] s;
    logic [6:0] glyphs [6] = '{7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h09};

    initial begin
        build_table();
        bus.HexSeg = 7'h7F;
        bus.SegValid = 1'b0;
        bus.AsciiReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_code", 32'(bus.AsciiCode), 32'h00);
        check("rst_valid", 32'(bus.AsciiValid), 32'h0);
        check("rst_ovf", 32'(bus.Overflow), 32'h0);
`ifdef SEG2ASCII_ERRCNT_EN
        check("rst_err", 32'(bus.ErrCount), 32'h0);
`endif
        reset = 1'b0;
        @(posedge clk);
        #1;

        // latency: 'A' held from cycle 0 shows up in cycle STAB+1
        bus.AsciiReady = 1'b1;
        bus.HexSeg = 7'h08;
        bus.SegValid = 1'b1;
        p0 = n_pops;
        first = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.AsciiValid && first < 0) first = k;
        end
        check("first_valid_cycle", 32'(first), 32'(STAB + 1));
        @(posedge clk);
        #1;
        hold(7'h7F, 6, 1, 0);
        check("single_pop_A", 32'(n_pops - p0), 32'd1);

        // blank separator allows a repeat; a SegValid gap alone does not
        p0 = n_pops;
        hold(7'h40, 6, 1, 0);
        hold(7'h7F, 4, 1, 0);
        hold(7'h40, 6, 1, 0);
        hold(7'h40, 3, 0, 0);
        hold(7'h40, 6, 1, 0);
        hold(7'h7F, 6, 1, 0);
        check("repeat_pops", 32'(n_pops - p0), 32'd2);

        // glitching shorter than the threshold never pushes
        p0 = n_pops;
        for (int i = 0; i < 10; i++) hold((i % 2) ? 7'h12 : 7'h06, 2, 1, 0);
        hold(7'h7F, 6, 1, 0);
        check("glitch_no_pop", 32'(n_pops - p0), 32'd0);

        // overflow: six glyphs into a four deep FIFO with no consumer
        do_reset();
        bus.AsciiReady = 1'b0;
        foreach (glyphs[i]) begin
            hold(glyphs[i], 5, 1, 0);
            hold(7'h7F, 5, 1, 0);
        end
        check("ovf_set", 32'(bus.Overflow), 32'h1);
        check("ovf_head", 32'(bus.AsciiCode), 32'h42);
`ifdef SEG2ASCII_ERRCNT_EN
        check("ovf_errcount", 32'(bus.ErrCount), 32'd2);
`endif
        p0 = n_pops;
        bus.AsciiReady = 1'b1;
        hold(7'h7F, 8, 1, 0);
        check("ovf_drain", 32'(n_pops - p0), 32'd4);

        // unknown glyph decodes to '?'
        do_reset();
        p0 = n_pops;
        bus.AsciiReady = 1'b1;
        hold(7'h3F, 6, 1, 0);
        hold(7'h7F, 4, 1, 0);
        check("unknown_pop", 32'(n_pops - p0), 32'd1);
`ifdef SEG2ASCII_ERRCNT_EN
        check("unknown_err", 32'(bus.ErrCount), 32'd1);
`endif

        // reset mid-stream clears the FIFO and the repeat memory
        bus.AsciiReady = 1'b0;
        hold(7'h03, 5, 1, 0);
        hold(7'h7F, 5, 1, 0);
        hold(7'h46, 5, 1, 0);
        hold(7'h7F, 5, 1, 0);
        hold(7'h08, 5, 1, 0);
        check("pre_rst_valid", 32'(bus.AsciiValid), 32'h1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.AsciiValid), 32'h0);
        check("mid_rst_ovf", 32'(bus.Overflow), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        p0 = n_pops;
        bus.AsciiReady = 1'b1;
        hold(7'h08, 6, 1, 0);
        hold(7'h08, 4, 1, 0);
        check("post_rst_A", 32'(n_pops - p0), 32'd1);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: s = 7'h7F;
                3:       s = 7'($urandom_range(0, 127));
                default: s = pats[$urandom_range(0, pats.size() - 1)];
            endcase
            hold(s, $urandom_range(1, 7), $urandom_range(0, 9) != 0, 1);
        end

        // drain with a cycle budget
        bus.AsciiReady = 1'b1;
        bus.SegValid = 1'b0;
        for (int k = 0; k < 100 && (expq.size() != 0 || bus.AsciiValid); k++) begin
            @(posedge clk);
            #1;
        end
        check("drained", 32'(expq.size()), 32'd0);
        check("final_valid", 32'(bus.AsciiValid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
